// File: rtl/trigger_bank.sv
// Multi-slot price trigger bank: each armed slot watches bid or ask against a
// stored threshold, latches one-shot on a hit and is reported lowest-index first.
module trigger_bank #(
  parameter int NUM_SLOTS = 8,
  parameter int PRICE_W   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         trigger_write_enable,
  input  logic                         trigger_cancel,
  input  logic [$clog2(NUM_SLOTS)-1:0] trigger_slot,
  input  logic                         trigger_side,
  input  logic                         trigger_direction,
  input  logic [PRICE_W-1:0]           trigger_price,
  input  logic                         quote_valid,
  input  logic [PRICE_W-1:0]           bid_price,
  input  logic [PRICE_W-1:0]           ask_price,
  input  logic                         fire_ready,
  output logic                         fire_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] fire_slot,
  output logic                         fire_side,
  output logic [PRICE_W-1:0]           fire_price,
  output logic [NUM_SLOTS-1:0]         armed_mask,
  output logic                         trigger_satisfied
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] armed;
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] side_q;
  logic [NUM_SLOTS-1:0] dir_q;
  logic [PRICE_W-1:0]   price_q   [NUM_SLOTS];
  logic [PRICE_W-1:0]   hit_q     [NUM_SLOTS];
  logic [PRICE_W-1:0]   ref_price [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit;
  logic [SLOT_W-1:0]    sel;
  logic                 pop;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ref_price[i] = side_q[i] ? ask_price : bid_price;
      hit[i] = quote_valid && armed[i] &&
               (dir_q[i] ? (ref_price[i] >= price_q[i]) : (ref_price[i] <= price_q[i]));
    end
  end

  // Scanning downward leaves the lowest pending index in sel.
  always_comb begin
    sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending[i]) sel = SLOT_W'(i);
    end
  end

  assign pop = fire_valid && fire_ready;

  // A write to a slot overrides both a pop and a quote hit on that slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      armed   <= '0;
      pending <= '0;
      side_q  <= '0;
      dir_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        price_q[i] <= '0;
        hit_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (trigger_write_enable && (trigger_slot == SLOT_W'(i))) begin
          armed[i]   <= !trigger_cancel;
          pending[i] <= 1'b0;
          if (!trigger_cancel) begin
            side_q[i]  <= trigger_side;
            dir_q[i]   <= trigger_direction;
            price_q[i] <= trigger_price;
          end
        end else if (pop && (sel == SLOT_W'(i))) begin
          pending[i] <= 1'b0;
        end else if (hit[i]) begin
          armed[i]   <= 1'b0;
          pending[i] <= 1'b1;
          hit_q[i]   <= ref_price[i];
        end
      end
    end
  end

  always_comb begin
    fire_valid        = |pending;
    fire_slot         = fire_valid ? sel : '0;
    fire_side         = fire_valid ? side_q[sel] : 1'b0;
    fire_price        = fire_valid ? hit_q[sel] : '0;
    armed_mask        = armed;
    trigger_satisfied = |pending;
  end

endmodule

// File: tb/tb_trigger_bank.sv
// Randomized plus directed bench for trigger_bank: a slot-level reference model
// predicts outputs, and a scoreboard checks every accepted fire event.
module tb_trigger_bank;
  localparam int N  = 8;
  localparam int PW = 8;
  localparam int SW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0, cancel = 1'b0, side = 1'b0, dir = 1'b0;
  logic [SW-1:0] slot = '0;
  logic [PW-1:0] tprice = '0, bid = '0, ask = '0;
  logic          qv = 1'b0, ready = 1'b0;
  logic          fire_valid, fire_side, trigger_satisfied;
  logic [SW-1:0] fire_slot;
  logic [PW-1:0] fire_price;
  logic [N-1:0]  armed_mask;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  int m_armed[N], m_pend[N], m_side[N], m_dir[N], m_price[N], m_hit[N];

  trigger_bank #(.NUM_SLOTS(N), .PRICE_W(PW)) dut (
    .clock(clock), .reset(reset),
    .trigger_write_enable(we), .trigger_cancel(cancel), .trigger_slot(slot),
    .trigger_side(side), .trigger_direction(dir), .trigger_price(tprice),
    .quote_valid(qv), .bid_price(bid), .ask_price(ask),
    .fire_ready(ready), .fire_valid(fire_valid), .fire_slot(fire_slot),
    .fire_side(fire_side), .fire_price(fire_price),
    .armed_mask(armed_mask), .trigger_satisfied(trigger_satisfied)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int lowest();
    for (int s = 0; s < N; s++) if (m_pend[s] != 0) return s;
    return -1;
  endfunction

  // Apply the rules of one clock edge to the slot model, using the inputs held this cycle.
  task automatic model_edge();
    int p;
    int r;
    if (!reset) begin
      for (int s = 0; s < N; s++) begin
        m_armed[s] = 0; m_pend[s] = 0; m_side[s] = 0;
        m_dir[s] = 0; m_price[s] = 0; m_hit[s] = 0;
      end
      return;
    end
    p = ready ? lowest() : -1;
    for (int s = 0; s < N; s++) begin
      if (we && int'(slot) == s) begin
        m_pend[s] = 0;
        m_armed[s] = cancel ? 0 : 1;
        if (!cancel) begin
          m_side[s] = int'(side); m_dir[s] = int'(dir); m_price[s] = int'(tprice);
        end
      end else if (s == p) begin
        m_pend[s] = 0;
      end else if (qv && m_armed[s] != 0) begin
        r = (m_side[s] != 0) ? int'(ask) : int'(bid);
        if ((m_dir[s] != 0 && r >= m_price[s]) || (m_dir[s] == 0 && r <= m_price[s])) begin
          m_armed[s] = 0; m_pend[s] = 1; m_hit[s] = r;
        end
      end
    end
  endtask

  task automatic checkOutput();
    int lo;
    int mask;
    lo = lowest();
    mask = 0;
    for (int s = 0; s < N; s++) if (m_armed[s] != 0) mask |= (1 << s);
    chk("fire_valid", int'(fire_valid), lo >= 0 ? 1 : 0);
    chk("trigger_satisfied", int'(trigger_satisfied), lo >= 0 ? 1 : 0);
    chk("armed_mask", int'(armed_mask), mask);
    chk("fire_slot", int'(fire_slot), lo >= 0 ? lo : 0);
    chk("fire_side", int'(fire_side), lo >= 0 ? m_side[lo] : 0);
    chk("fire_price", int'(fire_price), lo >= 0 ? m_hit[lo] : 0);
  endtask

  // Drive one cycle: the held inputs act at the next edge, then outputs are checked.
  task automatic applyStimulus();
    int lo;
    lo = lowest();
    if (ready && reset && lo >= 0) exp_q.push_back(lo * 1024 + m_side[lo] * 256 + m_hit[lo]);
    @(posedge clock);
    #1;
    model_edge();
    checkOutput();
    we = 1'b0;
    qv = 1'b0;
    reset = 1'b1;
  endtask

  task automatic arm(input int s, input int sd, input int dr, input int pr);
    we = 1'b1; cancel = 1'b0; slot = SW'(s); side = sd[0]; dir = dr[0]; tprice = PW'(pr);
  endtask

  task automatic quote(input int b, input int a);
    qv = 1'b1; bid = PW'(b); ask = PW'(a);
  endtask

  // Scoreboard: each accepted event must match the oldest predicted one.
  always @(negedge clock) begin
    if (reset && fire_valid && ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_pop: slot %0d with no predicted event", fire_slot);
      end else begin
        chk("sb_event", int'(fire_slot) * 1024 + int'(fire_side) * 256 + int'(fire_price),
            exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    applyStimulus();
    chk("reset_valid", int'(fire_valid), 0);

    arm(2, 0, 0, 100); applyStimulus();
    quote(101, 0); applyStimulus();
    chk("t1_no_fire_101", int'(fire_valid), 0);
    quote(100, 0); applyStimulus();
    chk("t1_slot", int'(fire_slot), 2);
    chk("t1_price", int'(fire_price), 100);
    chk("t1_mask2", int'(armed_mask[2]), 0);
    ready = 1'b1; applyStimulus(); ready = 1'b0;

    arm(5, 1, 1, 50); applyStimulus();
    arm(1, 1, 1, 40); applyStimulus();
    quote(0, 60); applyStimulus();
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_slot", int'(fire_slot), 1);
      applyStimulus();
    end
    ready = 1'b1; applyStimulus();
    chk("t2_next_slot", int'(fire_slot), 5);
    chk("t2_next_price", int'(fire_price), 60);
    applyStimulus();
    chk("t2_drained", int'(fire_valid), 0);
    ready = 1'b0;

    arm(3, 0, 1, 10); quote(200, 0); applyStimulus();
    chk("t3_write_wins", int'(fire_valid), 0);
    quote(200, 0); applyStimulus();
    chk("t3_fire_slot", int'(fire_slot), 3);
    ready = 1'b1; applyStimulus(); ready = 1'b0;

    arm(4, 0, 0, 255); applyStimulus();
    quote(7, 0); applyStimulus();
    we = 1'b1; cancel = 1'b1; slot = 3'd4; applyStimulus(); cancel = 1'b0;
    chk("t4_cancel_valid", int'(fire_valid), 0);
    chk("t4_cancel_mask", int'(armed_mask[4]), 0);

    arm(6, 0, 0, 200); applyStimulus();
    arm(7, 1, 1, 250); applyStimulus();
    quote(100, 10); applyStimulus();
    reset = 1'b0; applyStimulus();
    chk("t5_reset_valid", int'(fire_valid), 0);
    chk("t5_reset_mask", int'(armed_mask), 0);
    quote(100, 255); applyStimulus();
    chk("t5_no_fire", int'(fire_valid), 0);

    arm(0, 1, 1, 255); applyStimulus();
    quote(0, 255); applyStimulus();
    chk("t6_max_price", int'(fire_price), 255);
    ready = 1'b1; applyStimulus(); ready = 1'b0;
    arm(0, 0, 0, 0); applyStimulus();
    quote(0, 9); applyStimulus();
    chk("t6_zero_le", int'(fire_valid), 1);
    ready = 1'b1; applyStimulus(); ready = 1'b0;
    arm(0, 0, 1, 0); applyStimulus();
    quote(37, 9); applyStimulus();
    chk("t6_zero_ge", int'(fire_valid), 1);

    for (int c = 0; c < 3000; c++) begin
      we     = ($urandom % 4) == 0;
      cancel = ($urandom % 5) == 0;
      slot   = SW'($urandom % N);
      side   = 1'($urandom % 2);
      dir    = 1'($urandom % 2);
      tprice = PW'($urandom);
      qv     = ($urandom % 2) == 0;
      bid    = PW'($urandom);
      ask    = PW'($urandom);
      ready  = ($urandom % 3) != 0;
      reset  = ($urandom % 150) != 0;
      if (!reset) ready = 1'b0;
      applyStimulus();
    end

    ready = 1'b1;
    for (int c = 0; c < N + 2; c++) applyStimulus();
    ready = 1'b0;
    applyStimulus();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trigger_bank.md
# trigger_bank

Parametrised multi-slot price trigger bank, successor to the single-slot `trigger` block. Holds `NUM_SLOTS` independently armed triggers, each watching the bid or ask, and rising through or falling through a stored price. Each valid quote is checked against every armed slot. Slots that fire are latched one-shot and reported one at a time over a valid/ready interface to the downstream order logic.

## Interface
- `NUM_SLOTS`, 8: number of trigger slots; must be ≥2 and a power of two.
- `PRICE_W`, 8: width of all price fields, unsigned.
- `SLOT_W`, $clog2(NUM_SLOTS): localparam, width of slot indices.

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; all state is cleared on a rising edge with `reset`=0.
- `trigger_write_enable` in 1: write command to slot `trigger_slot`.
- `trigger_cancel` in 1: qualifies a write. 1 means disarm the slot; 0 means arm the slot with the fields below.
- `trigger_slot` in SLOT_W: target slot of the write.
- `trigger_side` in 1: 0 means watch `bid_price`; 1 means watch `ask_price`.
- `trigger_direction` in 1: 0 means fire when ref ≤ stored price; 1 means fire when ref ≥ stored price.
- `trigger_price` in PRICE_W: stored threshold.
- `quote_valid` in 1: `bid_price`/`ask_price` are valid this cycle.
- `bid_price` in PRICE_W: current best bid.
- `ask_price` in PRICE_W: current best ask.
- `fire_ready` in 1: consumer accepts the presented fire event.
- `fire_valid` out 1: a fired event is presented.
- `fire_slot` out SLOT_W: index of the presented slot.
- `fire_side` out 1: side of the presented slot.
- `fire_price` out PRICE_W: reference price captured when the slot fired.
- `armed_mask` out NUM_SLOTS: per-slot armed bits.
- `trigger_satisfied` out 1: OR of all pending bits. Kept for drop-in compatibility.

## Operation
- Per-slot state:
  - `armed`
  - `pending`
  - `side`
  - `dir`
  - `price`
  - `hit_price`
- `armed` and `pending` are never both 1.
- Slot lifecycle: IDLE (armed=0, pending=0) → ARMED → PENDING → IDLE.
  - IDLE → ARMED: arming write.
  - ARMED → PENDING: the slot's condition holds on a quote.
  - PENDING → IDLE: pop.
  - Any state → IDLE: cancel write.
  - Any state → ARMED with new fields: arm write. This also clears `pending`, and the unpopped event is discarded.
- Evaluation:
  - Applies on a cycle with `quote_valid`=1, for each slot with armed=1.
  - ref = side ? ask_price : bid_price.
  - hit = dir ? (ref ≥ price) : (ref ≤ price).
  - Full-width unsigned compare; equality fires in both directions.
- On hit, at the clock edge:
  - armed←0
  - pending←1
  - hit_price←ref
- Multiple slots may hit on the same quote; all become pending.
- Output selection: the lowest-index pending slot is presented combinationally from registered state. `fire_valid` = |pending.
- Pop: on `fire_valid` && `fire_ready` at an edge, the presented slot's pending←0. The next-lowest pending slot is presented the following cycle.
- While `fire_valid`=0, `fire_slot`, `fire_side` and `fire_price` are 0.
- Write vs. quote to the same slot in the same cycle: the write wins, and that quote is not evaluated for the slot. Other slots evaluate normally.
- Write vs. pop of the same slot in the same cycle: the write result stands, and the pop is consumed with no further effect.
- `quote_valid`=0: no evaluation; prices are ignored.

## Timing
- Reset values: all armed=0, pending=0, stored fields=0. Outputs:
  - `fire_valid`=0
  - `fire_slot`=0
  - `fire_side`=0
  - `fire_price`=0
  - `armed_mask`=0
  - `trigger_satisfied`=0
- Reset asserted mid-operation discards all armed and pending slots at that edge. Writes and quotes in a reset cycle are ignored.
- Write at edge t: `armed_mask` reflects it from t+1. The slot first evaluates the quote presented in the cycle after the write.
- Quote in cycle t that hits: `fire_valid`/`trigger_satisfied` high in cycle t+1. Latency is 1 clock.
- Throughput: one pop per cycle. Back-to-back pops with `fire_ready` held high drain k pending slots in k cycles.
- `fire_*` outputs are stable while `fire_valid`=1 and `fire_ready`=0, unless a lower-index slot becomes pending. In that case the lower index is presented from the next cycle. The consumer must not assume presented-slot stability before the handshake.

## Test plan
- Reset, then arm slot 2 (side=0, dir=0, price=100). Quote bid=101, then 100 → `fire_valid` in the cycle after bid=100, `fire_slot`=2, `fire_price`=100, `armed_mask[2]`=0.
- Arm slot 5 (side=1, dir=1, price=50) and slot 1 (side=1, dir=1, price=40). Quote ask=60 with `fire_ready`=0 for 3 cycles → slot 1 presented steadily. Assert `fire_ready` → slot 1 then slot 5 (`fire_price`=60) on consecutive cycles, then `fire_valid`=0.
- Arm slot 3 and, in the same cycle, present a hitting quote → no fire. A hitting quote next cycle → fire.
- Slot 4 pending, unpopped. Cancel slot 4 → `fire_valid`=0 next cycle, `armed_mask[4]`=0.
- Arm 2 slots and make 1 pending. Drive `reset`=0 for one edge → all outputs 0. Quotes that previously hit produce no fire.
- Price boundaries with PRICE_W=8: price=255, dir=1, ask=255 fires. Price=0, dir=0, bid=0 fires. Price=0, dir=1 fires on any quote.
